// File: rtl/hex_dec_display_driver.sv
// Hex/decimal multi-digit 7-segment driver with iterative double-dabble.
// Active-low glyphs, leading-zero blanking, overflow dashes, load/busy/done.
module hex_dec_display_driver #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      value,
   input  logic                  load,
   input  logic                  dec_mode,
   input  logic                  blank_lz,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int NB = (WIDTH + 2) / 3 + 1;
   localparam int BW = 4 * NB;
   localparam int SZ = (NB > DIGITS) ? NB : DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         bcd_q, bcd_d;
   logic [WIDTH-1:0]      bin_q, bin_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  dec_q, dec_d;
   logic                  blz_q, blz_d;
   logic [7*DIGITS-1:0]   seg_q, seg_d;
   logic                  ovf_q, ovf_d;
   logic                  done_q, done_d;

   logic [BW-1:0]         adj;
   logic [BW+WIDTH-1:0]   sh;
   logic [4*SZ-1:0]       src;
   logic [7*DIGITS-1:0]   img;
   logic                  ovf_n;
   logic                  lead;
   logic [3:0]            nib;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      unique case (d)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      blz_d   = blz_q;
      seg_d   = seg_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      adj = bcd_q;
      for (int j = 0; j < NB; j++) begin
         if (bcd_q[4*j +: 4] >= 4'd5)
            adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
      end
      sh = {adj, bin_q} << 1;

      // Hex source is the captured binary, zero-extended to BCD width
      src = '0;
      src[BW-1:0] = dec_q ? bcd_q : BW'(bin_q);

      ovf_n = 1'b0;
      for (int i = 0; i < SZ; i++) begin
         if (i >= DIGITS && src[4*i +: 4] != 4'd0)
            ovf_n = 1'b1;
      end

      lead = 1'b1;
      img  = '1;
      nib  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib  = src[4*i +: 4];
         lead = lead && (nib == 4'd0) && (i != 0);
         if (ovf_n)
            img[7*i +: 7] = DASH;
         else if (blz_q && lead)
            img[7*i +: 7] = BLANK;
         else
            img[7*i +: 7] = glyph(nib);
      end

      unique case (state_q)
         IDLE: begin
            if (load) begin
               dec_d = dec_mode;
               blz_d = blank_lz;
               bin_d = value;
               if (dec_mode) begin
                  bcd_d   = '0;
                  cnt_d   = CW'(WIDTH);
                  state_d = SHIFT;
               end else begin
                  state_d = FORMAT;
               end
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = FORMAT;
         end
         FORMAT: begin
            seg_d   = img;
            ovf_d   = ovf_n;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         blz_q   <= 1'b0;
         seg_q   <= '1;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         blz_q   <= blz_d;
         seg_q   <= seg_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign seg      = seg_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule
